lcd_bus_writer: RTL
===================

LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

Interface
REQ-001 Parameter T_SETUP, default 4, iCLK cycles from RS/DATA valid to LCD_EN rise (80 ns at 50 MHz).
REQ-002 Parameter T_EN_HI, default 16, iCLK cycles LCD_EN held high (320 ns).
REQ-003 Parameter T_HOLD, default 4, iCLK cycles RS/DATA held after LCD_EN fall.
REQ-004 Parameter T_EXEC, default 2000, iCLK cycles of execution wait for normal commands and data (40 us).
REQ-005 Parameter T_EXEC_LONG, default 82000, iCLK cycles of execution wait for clear/home (1.64 ms).
REQ-006 iCLK  input  1  sole clock, all state on rising edge.
REQ-007 iRST  input  1  asynchronous, active-high reset.
REQ-008 iDATA  input  8  command/character byte from the sequencer.
REQ-009 iRS  input  1  0 = instruction, 1 = character data.
REQ-010 iStart  input  1  write request; a rising edge requests one bus write.
REQ-011 oDone  output  1  one-cycle pulse when the write and its execution wait are complete.
REQ-012 oBusy  output  1  high from request acceptance until the cycle after oDone.
REQ-013 LCD_DATA  output  8  LCD data bus.
REQ-014 LCD_RW  output  1  read/write select, constant 0 (write only).
REQ-015 LCD_EN  output  1  LCD enable strobe.
REQ-016 LCD_RS  output  1  LCD register select.

Function
REQ-017 States: IDLE, SETUP, EN_HI, HOLD, EXEC, DONE; one-hot or binary encoding is an implementation choice.
REQ-018 iStart is registered each cycle; a request is a cycle with iStart=1 and the previous sample 0.
REQ-019 In IDLE, a request latches iDATA into LCD_DATA and iRS into LCD_RS, then moves to SETUP on the same edge.
REQ-020 A request outside IDLE is ignored and not queued; iStart held high never generates a second write.
REQ-021 SETUP lasts exactly T_SETUP cycles, then EN_HI.
REQ-022 LCD_EN = 1 only in EN_HI, which lasts exactly T_EN_HI cycles; LCD_EN is registered and glitch-free.
REQ-023 HOLD lasts T_HOLD cycles; LCD_DATA and LCD_RS stay unchanged through SETUP, EN_HI, HOLD and EXEC.
REQ-024 A long command is iRS=0 with latched byte 8'h01, 8'h02 or 8'h03; EXEC lasts T_EXEC_LONG cycles for these and T_EXEC otherwise.
REQ-025 DONE lasts one cycle with oDone=1, then IDLE; a request seen in the DONE cycle is ignored.
REQ-026 Total latency from request edge to oDone = T_SETUP+T_EN_HI+T_HOLD+T_EXEC(_LONG)+1 cycles.
REQ-027 The shared delay counter is at least 17 bits and loads (duration-1) on state entry; any parameter of 1 gives a one-cycle state, and 0 is illegal.
REQ-028 oBusy = (state != IDLE).

Reset
REQ-029 iRST asserts immediately, regardless of state: LCD_EN=0, LCD_RS=0, LCD_DATA=8'h00, LCD_RW=0, oDone=0, oBusy=0, state IDLE, counter 0.
REQ-030 The iStart history register resets to 1, so iStart high at reset release does not generate a request.
REQ-031 Reset during EN_HI truncates the strobe; no write is reported and the sequencer reissues the command.

Structure
REQ-032 Package lcd_pkg holds the state enumeration, default timing constants, and command codes CLR=8'h01 and HOME=8'h02.
REQ-033 One sub-module, lcd_timer: a loadable down-counter with a zero flag, instantiated once.
REQ-034 The block replaces the fixed 5.2 ms inter-command delay upstream; the sequencer relies only on oDone.

Verification
REQ-035 Request iRS=1, iDATA=8'h41 -> LCD_RS=1, LCD_DATA=8'h41; LCD_EN high exactly 16 cycles starting 4 cycles after acceptance; oDone at cycle 2025.
REQ-036 Request iRS=0, iDATA=8'h01 -> oDone exactly 82025 cycles after the request edge; request iRS=1, iDATA=8'h01 -> 2025 cycles.
REQ-037 iStart held high 5000 cycles -> exactly one EN pulse and one oDone.
REQ-038 Second iStart rising edge during EXEC -> ignored; no second EN pulse until a new edge after oDone.
REQ-039 iRST asserted on cycle 8 of EN_HI -> LCD_EN falls asynchronously, no oDone; after release, the next request completes normally.
REQ-040 iStart=1 at reset release -> no write until iStart goes low and then high again.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, default timing and command codes for the character-LCD bus writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_DONE  = 3'd5
    } lcd_state_t;

    // Defaults assume a 50 MHz iCLK.
    localparam int DEF_T_SETUP     = 4;
    localparam int DEF_T_EN_HI     = 16;
    localparam int DEF_T_HOLD      = 4;
    localparam int DEF_T_EXEC      = 2000;
    localparam int DEF_T_EXEC_LONG = 82000;
    localparam int MIN_CNT_W       = 17;

    localparam logic [7:0] CMD_CLR      = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and return-home need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module lcd_timer #(
    parameter int WIDTH = 17
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// Performs one timed HD44780-style bus write per iStart rising edge and
// reports completion only after the controller's execution time has elapsed.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP     = DEF_T_SETUP,
    parameter int T_EN_HI     = DEF_T_EN_HI,
    parameter int T_HOLD      = DEF_T_HOLD,
    parameter int T_EXEC      = DEF_T_EXEC,
    parameter int T_EXEC_LONG = DEF_T_EXEC_LONG
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int MAX_T = max_int(max_int(max_int(T_SETUP, T_EN_HI), max_int(T_HOLD, T_EXEC)),
                                   T_EXEC_LONG);
    localparam int CNT_W = max_int($clog2(MAX_T), MIN_CNT_W);

    // Each state is entered with (duration-1) so that a duration of 1 is a single cycle.
    localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN_HI     = CNT_W'(T_EN_HI - 1);
    localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

    lcd_state_t       state;
    lcd_state_t       state_nx;
    logic             start_q;
    logic             request;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;

    assign request = iStart & ~start_q;

    lcd_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .load      (timer_load),
        .load_value(timer_value),
        .zero      (timer_zero)
    );

    // History resets high so a start line already high at reset release is not an edge.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state   <= ST_IDLE;
            start_q <= 1'b1;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state   <= state_nx;
            start_q <= iStart;
            en_q    <= (state_nx == ST_EN_HI);
            if (state == ST_IDLE && request) begin
                data_q <= iDATA;
                rs_q   <= iRS;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (request) begin
                    state_nx    = ST_SETUP;
                    timer_load  = 1'b1;
                    timer_value = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    state_nx    = ST_EN_HI;
                    timer_load  = 1'b1;
                    timer_value = LD_EN_HI;
                end
            end
            ST_EN_HI: begin
                if (timer_zero) begin
                    state_nx    = ST_HOLD;
                    timer_load  = 1'b1;
                    timer_value = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    state_nx    = ST_EXEC;
                    timer_load  = 1'b1;
                    timer_value = is_long_cmd(rs_q, data_q) ? LD_EXEC_LONG : LD_EXEC;
                end
            end
            ST_EXEC: begin
                if (timer_zero) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign oDone    = (state == ST_DONE);
    assign oBusy    = (state != ST_IDLE);
    assign LCD_EN   = en_q;
    assign LCD_RS   = rs_q;
    assign LCD_DATA = data_q;
    assign LCD_RW   = 1'b0;

endmodule
